// File: rtl/aes_pkg.sv
// aes_pkg: constants shared by the AES round controller and its bus interface.
//   ST_IDLE/ST_RUN/ST_DONE : 2-bit controller state encodings
//   BLOCK_W                : AES block width
//   CNT_W                  : width of the datapath round counter
package aes_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned CNT_W   = 6;
endpackage

// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: bundles the three channels around the AES round controller.
//   input channel  : in_valid/in_ready/in_block plus key_in (expanded keys)
//   datapath side  : dp_in/dp_counter/dp_key out to Encryption, dp_out back
//   output channel : out_valid/out_ready/out_block, plus busy status
// Modports: slave = the controller, master = the wrapper/datapath around it.
interface aes_round_ctrl_if
  import aes_pkg::*;
#(
  parameter int unsigned KEY_W = 1417
);
  logic               in_valid;
  logic               in_ready;
  logic [BLOCK_W-1:0] in_block;
  logic [KEY_W-1:0]   key_in;
  logic [BLOCK_W-1:0] dp_in;
  logic [CNT_W-1:0]   dp_counter;
  logic [KEY_W-1:0]   dp_key;
  logic [BLOCK_W-1:0] dp_out;
  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] out_block;
  logic               busy;

  modport slave (
    input  in_valid, in_block, key_in, dp_out, out_ready,
    output in_ready, dp_in, dp_counter, dp_key, out_valid, out_block, busy
  );

  modport master (
    output in_valid, in_block, key_in, dp_out, out_ready,
    input  in_ready, dp_in, dp_counter, dp_key, out_valid, out_block, busy
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequences an iterative AES encryption datapath.
// Takes one plaintext block per valid/ready handshake, steps the datapath
// round counter 0..MAX_ROUND, captures the ciphertext on the last round and
// holds it on a valid/ready output channel until drained.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : aes_round_ctrl_if.slave (input, datapath and output channels)
// Options:
//   AES_CTRL_KEY_LATCH_EN : when defined, key_in is captured on accept and
//                           dp_key drives from that register; otherwise
//                           dp_key is key_in passed straight through.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned MAX_ROUND = 10,
  parameter int unsigned KEY_W     = 1417
) (
  input  logic             clk,
  input  logic             rst,
  aes_round_ctrl_if.slave  bus
);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLOCK_W-1:0] din_q, din_d;
  logic [BLOCK_W-1:0] oblk_q, oblk_d;
  logic               ov_q, ov_d;
  logic               busy_q, busy_d;
  logic               accept;
  logic               last_round;

  // Draining and accepting may share an edge, so ready looks through to
  // out_ready while a result is pending.
  assign bus.in_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign last_round   = (cnt_q == CNT_W'(MAX_ROUND));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    oblk_d  = oblk_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          din_d   = bus.in_block;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_round) begin
          oblk_d  = bus.dp_out;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          if (accept) begin
            din_d   = bus.in_block;
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    // Status flags are registered copies of the next state.
    ov_d   = (state_d == ST_DONE);
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      din_q   <= '0;
      oblk_q  <= '0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      oblk_q  <= oblk_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
    end
  end

`ifdef AES_CTRL_KEY_LATCH_EN
  logic [KEY_W-1:0] key_q, key_d;

  always_comb key_d = accept ? bus.key_in : key_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) key_q <= '0;
    else     key_q <= key_d;
  end

  assign bus.dp_key = key_q;
`else
  // Caller holds key_in stable from accept until the result is captured.
  assign bus.dp_key = bus.key_in;
`endif

  assign bus.dp_in      = din_q;
  assign bus.dp_counter = cnt_q;
  assign bus.out_block  = oblk_q;
  assign bus.out_valid  = ov_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed checks of aes_round_ctrl against a behavioural
// stand-in for the Encryption datapath. The stand-in returns the FIPS-197
// ciphertext for the FIPS plaintext/key pair, a simple mix of plaintext and key
// for other blocks, and junk on every round except the last, so capturing on
// the wrong round shows up as a wrong ciphertext.
module tb_aes_round_ctrl;
  import aes_pkg::*;

  localparam int unsigned KEY_W = 1417;
  localparam int unsigned MAXR  = 10;

  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [KEY_W-1:0] FIPS_KEY = KEY_W'(128'h000102030405060708090a0b0c0d0e0f);

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;

  aes_round_ctrl_if #(.KEY_W(KEY_W)) bus ();

  aes_round_ctrl #(.MAX_ROUND(MAXR), .KEY_W(KEY_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stand-in
  always_comb begin
    if (bus.dp_counter == CNT_W'(MAXR)) begin
      if (bus.dp_in == FIPS_PT && bus.dp_key == FIPS_KEY) bus.dp_out = FIPS_CT;
      else bus.dp_out = bus.dp_in ^ bus.dp_key[127:0] ^ {16{8'ha5}};
    end else begin
      bus.dp_out = {16{8'h3c}} ^ {122'd0, bus.dp_counter};
    end
  end

  typedef struct {
    string            name;
    logic [127:0]     pt;
    logic [KEY_W-1:0] key;
    logic [127:0]     ct;
  } vec_t;

  vec_t vecs [3];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits up to max_cyc edges for out_valid; n = edges waited.
  task automatic wait_ov(input int max_cyc, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < max_cyc && !ok) begin
      tick();
      n++;
      if (bus.out_valid) ok = 1'b1;
    end
  endtask

  // Offers a block from IDLE, checks counter sequence, latency and ciphertext,
  // then drains.
  task automatic run_block(input string nm, input logic [127:0] pt,
                           input logic [KEY_W-1:0] key, input logic [127:0] ct);
    int  n;
    bit  cnt_ok;
    bit  ok;
    bus.in_valid = 1'b1;
    bus.in_block = pt;
    bus.key_in   = key;
    chk({nm, "_in_ready"}, 128'(bus.in_ready), 128'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_block = '0;
    cnt_ok = (bus.dp_counter == 0) && bus.busy;
    n  = 0;
    ok = 1'b0;
    while (n < 40 && !ok) begin
      tick();
      n++;
      if (bus.out_valid) ok = 1'b1;
      else if (bus.dp_counter != CNT_W'(n)) cnt_ok = 1'b0;
    end
    chk({nm, "_cnt_seq"}, 128'(cnt_ok), 128'd1);
    chk({nm, "_latency"}, 128'(ok ? n : -1), 128'(MAXR + 1));
    chk({nm, "_ct"}, bus.out_block, ct);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({nm, "_drained"}, 128'({bus.out_valid, bus.busy}), 128'd0);
  endtask

  initial begin
    int  n, t1, t2, pulses;
    bit  ok, stable;
    logic [127:0] held;

    total = 0;
    bad   = 0;
    cyc   = 0;
    vecs[0] = '{"fips", FIPS_PT, FIPS_KEY, FIPS_CT};
    vecs[1] = '{"ones", {128{1'b1}}, KEY_W'({16{8'h0f}}), {16{8'h55}}};
    vecs[2] = '{"one",  128'd1, '0, {{15{8'ha5}}, 8'ha4}};

    bus.in_valid  = 1'b0;
    bus.in_block  = '0;
    bus.key_in    = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    chk("rst_in_ready",  128'(bus.in_ready), 128'd1);
    chk("rst_flags",     128'({bus.out_valid, bus.busy}), 128'd0);
    chk("rst_counter",   128'(bus.dp_counter), 128'd0);
    chk("rst_dp_in",     bus.dp_in, 128'd0);
    chk("rst_out_block", bus.out_block, 128'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 3; i++) run_block(vecs[i].name, vecs[i].pt, vecs[i].key, vecs[i].ct);

    // Backpressure: result held for 5 cycles with out_ready low.
    bus.in_valid = 1'b1;
    bus.in_block = FIPS_PT;
    bus.key_in   = FIPS_KEY;
    tick();
    bus.in_valid = 1'b0;
    wait_ov(40, n, ok);
    chk("bp_valid", 128'(ok), 128'd1);
    held   = bus.out_block;
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (!bus.out_valid || bus.out_block !== held || bus.in_ready) stable = 1'b0;
      tick();
    end
    chk("bp_stable", 128'(stable), 128'd1);
    chk("bp_ct", bus.out_block, FIPS_CT);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_ready_follows", 128'(bus.in_ready), 128'd1);
    tick();
    bus.out_ready = 1'b0;
    chk("bp_drained", 128'(bus.out_valid), 128'd0);

    // Back-to-back with in_valid and out_ready high.
    bus.key_in    = '0;
    bus.in_block  = {128{1'b1}} ^ 128'h0f0f;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    wait_ov(40, n, ok);
    t1 = cyc;
    chk("b2b_first_valid", 128'(ok), 128'd1);
    chk("b2b_first_ct", bus.out_block, ({128{1'b1}} ^ 128'h0f0f) ^ {16{8'ha5}});
    chk("b2b_ready", 128'(bus.in_ready), 128'd1);
    bus.in_block = 128'd1;
    tick();
    bus.in_valid = 1'b0;
    chk("b2b_second_accept", {bus.dp_in[125:0], bus.busy, bus.out_valid}, {126'd1, 2'b10});
    wait_ov(40, n, ok);
    t2 = cyc;
    chk("b2b_period", 128'(ok ? t2 - t1 : -1), 128'(MAXR + 2));
    chk("b2b_second_ct", bus.out_block, {{15{8'ha5}}, 8'ha4});
    tick();
    bus.out_ready = 1'b0;
    chk("b2b_idle", 128'({bus.out_valid, bus.busy}), 128'd0);

    // in_valid pulse during RUN must be ignored.
    bus.in_valid = 1'b1;
    bus.in_block = FIPS_PT;
    bus.key_in   = FIPS_KEY;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.dp_counter != 6'd4 && n < 20) begin
      tick();
      n++;
    end
    chk("ign_reached4", 128'(bus.dp_counter), 128'd4);
    bus.in_valid = 1'b1;
    bus.in_block = 128'hdeadbeef;
    #1;
    chk("ign_in_ready", 128'(bus.in_ready), 128'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("ign_dp_in", bus.dp_in, FIPS_PT);
    wait_ov(40, n, ok);
    chk("ign_ct", bus.out_block, FIPS_CT);
    bus.out_ready = 1'b1;
    tick();
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      if (bus.out_valid || bus.busy) pulses++;
      tick();
    end
    bus.out_ready = 1'b0;
    chk("ign_no_extra", 128'(pulses), 128'd0);

    // Reset at dp_counter==7 aborts the block.
    bus.in_valid = 1'b1;
    bus.in_block = FIPS_PT;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.dp_counter != 6'd7 && n < 20) begin
      tick();
      n++;
    end
    chk("rstm_reached7", 128'(bus.dp_counter), 128'd7);
    rst = 1'b1;
    #1;
    chk("rstm_counter", 128'(bus.dp_counter), 128'd0);
    chk("rstm_regs", bus.dp_in | bus.out_block, 128'd0);
    chk("rstm_flags", 128'({bus.in_ready, bus.out_valid, bus.busy}), 128'b100);
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (bus.out_valid) pulses++;
    end
    chk("rstm_no_valid", 128'(pulses), 128'd0);
    run_block("after_rst", FIPS_PT, FIPS_KEY, FIPS_CT);

`ifdef AES_CTRL_KEY_LATCH_EN
    // Key may change after accept when it is latched.
    bus.in_valid = 1'b1;
    bus.in_block = FIPS_PT;
    bus.key_in   = FIPS_KEY;
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.key_in = '1;
    wait_ov(40, n, ok);
    chk("latch_valid", 128'(ok), 128'd1);
    chk("latch_ct", bus.out_block, FIPS_CT);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
